pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Consumer of the hazard and redirect requests in the 5-stage core. It turns load-use stalls, data-memory waits, taken branches and traps into per-register enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also times out hung memory accesses and keeps saturating performance counters. It sits in the core top level, downstream of the hazard detection unit and beside the pipeline registers it drives.

## Interface
- TIMEOUT, 16: consecutive memory-stall cycles before the timeout error (>= 2).
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- hazard_stall  in  1  load-use stall request from hazard detection (ID stage).
- branch_taken  in  1  taken branch/jump resolved in EX.
- dmem_req  in  1  MEM stage is issuing a data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- trap_req  in  1  trap/exception request; level, held until trap_ack.
- clr_counters  in  1  synchronous clear of both counters.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble at the next edge; flush overrides en=0.
- trap_ack  out  1  one-cycle pulse; the trap redirect and flush happen this cycle.
- mem_timeout  out  1  one-cycle pulse; memory access aborted and the PC unit loads the trap vector.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0.
- flush_events  out  CNT_W  count of redirect cycles (branch, trap_ack, timeout).

## Operation
- FSM states: RUN, MEM_WAIT, ERR. wait_cnt is a counter of width clog2(TIMEOUT+1).
- mem_stall = dmem_req & !dmem_ready & (state != ERR).
- Outputs in RUN/MEM_WAIT are combinational from the inputs, with this priority:
  1. mem_stall: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_en=1; memwb_flush=1. Other flushes are 0 and trap_ack=0; trap and branch are deferred.
  2. trap_req: all en=1; ifid_flush, idex_flush and exmem_flush are 1; trap_ack=1.
  3. branch_taken: all en=1; ifid_flush=idex_flush=1. A simultaneous hazard_stall is ignored because the dependent instruction is flushed.
  4. hazard_stall: pc_en=ifid_en=0; idex_flush=1; the remaining en are 1.
  5. Otherwise: all en=1, all flush=0.
- ERR state outputs:
  - mem_timeout=1; all en=1; ifid_flush, idex_flush, exmem_flush and memwb_flush are 1.
  - trap_ack=0; all other inputs are ignored.
- Transitions:
  - RUN to MEM_WAIT when mem_stall; wait_cnt set to 1.
  - MEM_WAIT with mem_stall: if wait_cnt == TIMEOUT-1, go to ERR; otherwise wait_cnt += 1.
  - MEM_WAIT without mem_stall: go to RUN, wait_cnt=0.
  - ERR to RUN unconditionally, wait_cnt=0.
- Counters:
  - stall_cycles increments on every cycle with pc_en=0.
  - flush_events increments on every cycle with trap_ack, a branch flush, or ERR.
  - Both saturate at all-ones. clr_counters wins over increment.

## Timing
- While rst_n is low, asynchronously:
  - state=RUN, wait_cnt=0, counters 0.
  - All en=0, all flush=1, trap_ack=0, mem_timeout=0.
- After release, outputs follow the rules above in the same cycle.
- Zero-cycle latency from any request input to the controls; FSM and counters update at the edge.
- A load-use stall lasts exactly as long as hazard_stall is high; normally 1 cycle.
- Timeout: ERR is entered after TIMEOUT consecutive stalled cycles and lasts exactly 1 cycle.
- dmem_ready arriving in the same cycle as the would-be timeout edge: not a stall, so return to RUN with no ERR.
- A trap held through a memory wait is acknowledged in the first cycle with dmem_ready=1. trap_req still high in the ERR cycle gets no ack; it is acked in the next RUN cycle.
- Asserting rst_n low mid-wait aborts immediately; no mem_timeout pulse.

## Test plan
- Reset: rst_n=0 gives all en=0, all flush=1, counters 0. Release with idle inputs gives all en=1, flush=0.
- Load-use: hazard_stall=1 for 1 cycle gives pc_en=0, ifid_en=0, idex_flush=1, and stall_cycles goes 0 to 1.
- Branch with hazard_stall in the same cycle gives pc_en=1, ifid_flush=idex_flush=1, stall_cycles unchanged, flush_events +1.
- Trap during memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, trap_req high.
  - During the wait: front-end frozen, memwb_flush=1, trap_ack=0.
  - On the dmem_ready=1 cycle: trap_ack=1, and ifid/idex/exmem flushes=1.
  - stall_cycles +3.
- Timeout with TIMEOUT=4 and dmem_ready stuck at 0: 4 frozen cycles, then 1 ERR cycle with mem_timeout=1 and all flush=1, then RUN. A dmem_ready on the 4th cycle gives no ERR.
- Counters with CNT_W=4: 20 stall cycles saturate stall_cycles at 15. clr_counters together with a stall clears it to 0.

Source files
------------

// File: rtl/pipeline_stall_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_if
//
// Purpose: bundles the hazard/redirect request inputs, the per-register
// enable/flush controls and the performance counters of the pipeline stall
// controller into one connection.
//
// Signals:
//   hazard_stall  load-use stall request from hazard detection (ID stage)
//   branch_taken  taken branch/jump resolved in EX
//   dmem_req      MEM stage is issuing a data-memory access
//   dmem_ready    data memory completes the access this cycle
//   trap_req      trap/exception request, held until trap_ack
//   clr_counters  synchronous clear of both performance counters
//   pc_en .. memwb_en             pipeline register load enables
//   ifid_flush .. memwb_flush     load a bubble at the next edge
//   trap_ack      one-cycle pulse, trap redirect happens this cycle
//   mem_timeout   one-cycle pulse, hung memory access aborted
//   stall_cycles  saturating count of cycles with pc_en=0
//   flush_events  saturating count of redirect cycles
//
// Modports:
//   master  the core side that raises requests and consumes the controls
//   slave   the stall controller itself
// ---------------------------------------------------------------------------
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 32
);

  logic             hazard_stall;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             trap_req;
  logic             clr_counters;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             trap_ack;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output hazard_stall, branch_taken, dmem_req, dmem_ready, trap_req,
           clr_counters,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           trap_ack, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  hazard_stall, branch_taken, dmem_req, dmem_ready, trap_req,
           clr_counters,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           trap_ack, mem_timeout, stall_cycles, flush_events
  );

endinterface

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Purpose: turns load-use stalls, data-memory waits, taken branches and traps
// into enable/flush controls for the PC and the four pipeline registers of
// the 5-stage core. A data-memory access that stays stalled for TIMEOUT
// consecutive cycles is aborted with a one-cycle mem_timeout pulse. Two
// saturating performance counters track stalled and redirect cycles.
//
// Parameters:
//   TIMEOUT  consecutive memory-stall cycles before the timeout error (>= 2)
//   CNT_W    width of the performance counters
//
// Ports:
//   clk    core clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipeline_stall_controller_if slave modport (requests in,
//          enables/flushes/acks/counters out)
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_stall_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_t;

  localparam int              WCW       = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WCW-1:0]   wait_cnt;
  logic [WCW-1:0]   wait_cnt_nxt;

  logic             mem_stall;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             trap_ack;
  logic             mem_timeout;
  logic             branch_flush;

  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             stall_inc;
  logic             flush_inc;

  // A memory access only counts as stalling outside the error cycle; in ERR
  // the access is being aborted, so a still-pending request is ignored.
  assign mem_stall = bus.dmem_req & ~bus.dmem_ready & (state != ERR);

  // State register and wait counter. Reset is asynchronous so pulling rst_n
  // low in the middle of a memory wait abandons it without a timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and control outputs. The controls are purely combinational
  // from the requests so the pipeline reacts in the same cycle. A memory
  // stall outranks everything: traps and branches wait until the access
  // completes, and the MEM/WB bubble keeps the stalled load from writing
  // back twice. While rst_n is low every register loads a bubble.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    trap_ack     = 1'b0;
    mem_timeout  = 1'b0;
    branch_flush = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERR;
          end else begin
            wait_cnt_nxt = wait_cnt + WCW'(1);
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      ERR: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state == ERR) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      mem_timeout = 1'b1;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (bus.trap_req) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      trap_ack    = 1'b1;
    end else if (bus.branch_taken) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      branch_flush = 1'b1;
    end else if (bus.hazard_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign stall_inc = ~pc_en;
  assign flush_inc = trap_ack | branch_flush | mem_timeout;

  // Saturating performance counters. A clear request takes precedence over
  // an increment in the same cycle, and a counter at all-ones stays there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (bus.clr_counters) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_inc && (flush_events != {CNT_W{1'b1}})) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

  // Drive the interface from the internal control nets.
  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_flush  = memwb_flush;
  assign bus.trap_ack     = trap_ack;
  assign bus.mem_timeout  = mem_timeout;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_events = flush_events;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Purpose: self-checking bench for pipeline_stall_controller with TIMEOUT=4
// and CNT_W=4. Each cycle the expected controls and counter values are
// computed from a small behavioural model and queued as stimulus is driven,
// then popped and compared once the DUT outputs have settled.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [10:0] ctl;
    int          stall_cnt;
    int          flush_cnt;
  } expect_t;

  logic clk;
  logic rst_n;

  pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_controller #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  expect_t exp_q[$];

  int n_compared;
  int n_mismatched;

  bit m_err;
  int m_run;
  int m_stall_cnt;
  int m_flush_cnt;

  // Free-running core clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want,
               $time);
    end
  endtask

  // Drives one cycle of inputs, predicts the controls and counters from the
  // model, queues the prediction, checks the settled DUT against it and then
  // advances the model across the rising edge.
  task automatic applyStimulus(input logic rst, input logic hz,
                               input logic br, input logic rq,
                               input logic rd, input logic tr,
                               input logic clr, input string tag);
    expect_t e;
    expect_t got;
    logic pc, ifd, idx, exm, mwb, fif, fid, fex, fmw, ack, tmo;
    logic ms, brf;
    bit   n_err;
    int   n_run, n_sc, n_fc;

    @(negedge clk);
    rst_n              = rst;
    bus.hazard_stall   = hz;
    bus.branch_taken   = br;
    bus.dmem_req       = rq;
    bus.dmem_ready     = rd;
    bus.trap_req       = tr;
    bus.clr_counters   = clr;

    {pc, ifd, idx, exm, mwb} = 5'b11111;
    {fif, fid, fex, fmw}     = 4'b0000;
    ack = 1'b0;
    tmo = 1'b0;
    brf = 1'b0;
    ms  = rq & ~rd & ~m_err;

    if (!rst) begin
      {pc, ifd, idx, exm, mwb} = 5'b00000;
      {fif, fid, fex, fmw}     = 4'b1111;
    end else if (m_err) begin
      {fif, fid, fex, fmw} = 4'b1111;
      tmo = 1'b1;
    end else if (ms) begin
      {pc, ifd, idx, exm} = 4'b0000;
      fmw = 1'b1;
    end else if (tr) begin
      {fif, fid, fex} = 3'b111;
      ack = 1'b1;
    end else if (br) begin
      {fif, fid} = 2'b11;
      brf = 1'b1;
    end else if (hz) begin
      {pc, ifd} = 2'b00;
      fid = 1'b1;
    end

    e.ctl       = {pc, ifd, idx, exm, mwb, fif, fid, fex, fmw, ack, tmo};
    e.stall_cnt = rst ? m_stall_cnt : 0;
    e.flush_cnt = rst ? m_flush_cnt : 0;
    exp_q.push_back(e);

    if (!rst) begin
      n_err = 1'b0;
      n_run = 0;
      n_sc  = 0;
      n_fc  = 0;
    end else begin
      if (m_err) begin
        n_err = 1'b0;
        n_run = 0;
      end else if (ms) begin
        n_run = m_run + 1;
        n_err = (n_run == TIMEOUT);
        if (n_err) n_run = 0;
      end else begin
        n_err = 1'b0;
        n_run = 0;
      end
      if (clr) begin
        n_sc = 0;
        n_fc = 0;
      end else begin
        n_sc = (!pc && m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : m_stall_cnt;
        n_fc = ((ack || brf || tmo) && m_flush_cnt < CNT_MAX) ?
               m_flush_cnt + 1 : m_flush_cnt;
      end
    end

    #1;
    got = exp_q.pop_front();
    checkOutput({tag, ".ctl"},
                64'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                     bus.memwb_en, bus.ifid_flush, bus.idex_flush,
                     bus.exmem_flush, bus.memwb_flush, bus.trap_ack,
                     bus.mem_timeout}),
                64'(got.ctl));
    checkOutput({tag, ".stall_cycles"}, 64'(bus.stall_cycles),
                64'(got.stall_cnt));
    checkOutput({tag, ".flush_events"}, 64'(bus.flush_events),
                64'(got.flush_cnt));

    @(posedge clk);
    m_err       = n_err;
    m_run       = n_run;
    m_stall_cnt = n_sc;
    m_flush_cnt = n_fc;
  endtask

  // Directed scenarios followed by a short random run.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_err        = 1'b0;
    m_run        = 0;
    m_stall_cnt  = 0;
    m_flush_cnt  = 0;

    rst_n            = 1'b0;
    bus.hazard_stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.trap_req     = 1'b0;
    bus.clr_counters = 1'b0;

    $display("[TB] reset and idle");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "reset0");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "reset1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "idle0");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "idle1");

    $display("[TB] load-use stall");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, "loaduse");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "loaduse_after");

    $display("[TB] branch with hazard");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, "branch_hz");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "branch_after");

    $display("[TB] trap held through memory wait");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 1, 0, 1, 0, $sformatf("trapwait%0d", i));
    applyStimulus(1, 0, 0, 1, 1, 1, 0, "trap_ack");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "trap_after");

    $display("[TB] memory timeout");
    for (int i = 0; i < TIMEOUT; i++)
      applyStimulus(1, 0, 0, 1, 0, 0, 0, $sformatf("tmo_wait%0d", i));
    applyStimulus(1, 0, 0, 1, 0, 0, 0, "tmo_err");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "tmo_run");

    $display("[TB] timeout with trap pending through error cycle");
    for (int i = 0; i < TIMEOUT; i++)
      applyStimulus(1, 0, 0, 1, 0, 1, 0, $sformatf("tmotrap_wait%0d", i));
    applyStimulus(1, 0, 0, 0, 0, 1, 0, "tmotrap_err");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, "tmotrap_ack");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "tmotrap_after");

    $display("[TB] ready on the would-be timeout cycle");
    for (int i = 0; i < TIMEOUT - 1; i++)
      applyStimulus(1, 0, 0, 1, 0, 0, 0, $sformatf("late_wait%0d", i));
    applyStimulus(1, 0, 0, 1, 1, 0, 0, "late_ready");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "late_after");

    $display("[TB] reset in the middle of a wait");
    applyStimulus(1, 0, 0, 1, 0, 0, 0, "midrst_wait0");
    applyStimulus(1, 0, 0, 1, 0, 0, 0, "midrst_wait1");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, "midrst_reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "midrst_idle0");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "midrst_idle1");

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 1, 0, 0, 0, 0, 0, $sformatf("sat%0d", i));
    applyStimulus(1, 1, 0, 0, 0, 0, 1, "clr_with_stall");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "clr_after");

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      logic hz, br, rq, rd, tr, clr;
      hz  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      rq  = ($urandom_range(0, 1) == 0);
      rd  = ($urandom_range(0, 3) == 0);
      tr  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      applyStimulus(1, hz, br, rq, rd, tr, clr, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
